// File: rtl/sniffer_pkg.sv
// Shared types and defaults for the packet-sniffer match logging path.
package sniffer_pkg;

   localparam int LOG_DEPTH_DEFAULT = 16;
   localparam int SEQ_W_DEFAULT     = 16;

   typedef struct packed {
      logic url;
      logic mac;
      logic ip;
      logic port;
   } match_flags_t;

   typedef struct packed {
      logic [SEQ_W_DEFAULT-1:0] seq;
      match_flags_t             flags;
   } match_rec_t;

endpackage

// File: rtl/match_log_ram.sv
// Simple dual-port record store: one write port, one registered read port.
module match_log_ram #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Array has no reset so it maps onto plain RAM; same-address read returns old data.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/match_log_buffer.sv
// Circular log of comparator match flags tagged with packet sequence numbers.
// Define MATCH_LOG_OVERWRITE_EN to overwrite the oldest record when full instead of dropping.
module match_log_buffer
   import sniffer_pkg::*;
#(
   parameter int DEPTH  = LOG_DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int SEQ_W  = SEQ_W_DEFAULT,
   parameter int OVF_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_eop,
   input  logic              pkt_valid,
   input  logic              inc_addr,
   input  logic              port_match,
   input  logic              ip_match,
   input  logic              mac_match,
   input  logic              url_match,
   input  logic              rd_req,
   output logic [SEQ_W+3:0]  rd_data,
   output logic              rd_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic [OVF_W-1:0]  ovf_cnt
);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [OVF_W-1:0]  ovf_q, ovf_d;
   logic              full_q, empty_q, rd_valid_q;
   logic              rd_acc, wr_acc, drop, wr_en, rd_adv;
   match_flags_t      flags;

   assign flags = '{url: url_match, mac: mac_match, ip: ip_match, port: port_match};

   always_comb begin
      rd_acc = rd_req & ~empty_q;
      // A full buffer still takes a write when a read frees a slot in the same cycle.
      wr_acc = inc_addr & (~full_q | rd_acc);
      drop   = inc_addr & full_q & ~rd_acc;
`ifdef MATCH_LOG_OVERWRITE_EN
      wr_en  = wr_acc | drop;
      rd_adv = rd_acc | drop;
`else
      wr_en  = wr_acc;
      rd_adv = rd_acc;
`endif
      wr_ptr_d = wr_en  ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d = rd_adv ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

      count_d = count_q;
      if (wr_acc && !rd_acc)      count_d = count_q + (ADDR_W+1)'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - (ADDR_W+1)'(1);

      ovf_d = ovf_q;
      if (drop && (ovf_q != {OVF_W{1'b1}})) ovf_d = ovf_q + OVF_W'(1);

      seq_d = (pkt_eop & pkt_valid) ? seq_q + SEQ_W'(1) : seq_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         seq_q      <= '0;
         count_q    <= '0;
         ovf_q      <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         seq_q      <= seq_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         full_q     <= (count_d == (ADDR_W+1)'(DEPTH));
         empty_q    <= (count_d == '0);
         rd_valid_q <= rd_acc;
      end
   end

   match_log_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (SEQ_W + 4)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i ({seq_q, flags}),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_match_log_buffer.sv
// Randomized bench for match_log_buffer against a queue-based record model.
module tb_match_log_buffer;
   import sniffer_pkg::*;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        pkt_eop, pkt_valid, inc_addr;
   logic        port_match, ip_match, mac_match, url_match;
   logic        rd_req;
   logic [19:0] rd_data;
   logic        rd_valid;
   logic [4:0]  count;
   logic        full, empty;
   logic [15:0] ovf_cnt;

   match_log_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .pkt_eop    (pkt_eop),
      .pkt_valid  (pkt_valid),
      .inc_addr   (inc_addr),
      .port_match (port_match),
      .ip_match   (ip_match),
      .mac_match  (mac_match),
      .url_match  (url_match),
      .rd_req     (rd_req),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .ovf_cnt    (ovf_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: the buffer is just a FIFO of records.
   logic [19:0] exp_q[$];
   int unsigned m_seq, m_ovf;
   logic        m_rdv;
   logic [19:0] m_rdd;
   int          n_cmp, n_err;

   task automatic idle_inputs();
      inc_addr = 0; pkt_eop = 0; pkt_valid = 0; rd_req = 0;
      {url_match, mac_match, ip_match, port_match} = 4'b0000;
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_seq = 0; m_ovf = 0; m_rdv = 0; m_rdd = '0;
   endtask

   task automatic step(input bit inc, input logic [3:0] fl, input bit eop, input bit vld,
                       input bit req);
      match_rec_t rec;
      bit         acc;
      inc_addr = inc; pkt_eop = eop; pkt_valid = vld; rd_req = req;
      {url_match, mac_match, ip_match, port_match} = fl;
      acc   = req && (exp_q.size() > 0);
      m_rdv = acc;
      if (acc) m_rdd = exp_q.pop_front();
      if (inc) begin
         rec.seq   = m_seq[15:0];
         rec.flags = fl;
         if (exp_q.size() < DEPTH) exp_q.push_back(rec);
         else begin
            if (m_ovf < 65535) m_ovf++;
`ifdef MATCH_LOG_OVERWRITE_EN
            void'(exp_q.pop_front());
            exp_q.push_back(rec);
`endif
         end
      end
      if (eop && vld) m_seq = (m_seq + 1) % 65536;
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp += 6;
      if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
      if (rd_data !== 20'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
      if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
      if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      if (ovf_cnt !== 16'd0) begin n_err++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
   endtask

   task automatic test_seq_capture();
      logic [19:0] want;
      want = {16'd3, 4'b1001};
      repeat (3) step(0, 4'b0000, 1, 1, 0);
      step(0, 4'b0000, 1, 0, 0);            // eop without valid must not count
      step(1, 4'b1001, 0, 0, 0);
      n_cmp++;
      if (count !== 5'd1) begin n_err++; $display("FAIL seq_wr_count got %0d want 1", count); end
      step(0, 4'b0000, 0, 0, 1);
      n_cmp += 4;
      if (rd_valid !== 1'b1) begin n_err++; $display("FAIL seq_rd_valid got %b want 1", rd_valid); end
      if (rd_data !== want) begin n_err++; $display("FAIL seq_rd_data got %h want %h", rd_data, want); end
      if (count !== 5'd0) begin n_err++; $display("FAIL seq_rd_count got %0d want 0", count); end
      if (empty !== 1'b1) begin n_err++; $display("FAIL seq_rd_empty got %b want 1", empty); end
   endtask

   task automatic test_eop_same_cycle();
      logic [19:0] want;
      want = {16'd5, 4'b0110};
      repeat (2) step(0, 4'b0000, 1, 1, 0);
      step(1, 4'b0110, 1, 1, 0);
      step(0, 4'b0000, 0, 0, 1);
      n_cmp++;
      if (rd_data !== want) begin n_err++; $display("FAIL eop_same_data got %h want %h", rd_data, want); end
      step(1, 4'b0000, 0, 0, 0);
      step(0, 4'b0000, 0, 0, 1);
      n_cmp++;
      if (rd_data[19:4] !== 16'd6) begin n_err++; $display("FAIL eop_post_seq got %0d want 6", rd_data[19:4]); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < 17; i++) step(1, 4'($urandom_range(0, 15)), 1, 1, 0);
      n_cmp += 3;
      if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
      if (count !== 5'd16) begin n_err++; $display("FAIL fill_count got %0d want 16", count); end
      if (ovf_cnt !== 16'd1) begin n_err++; $display("FAIL fill_ovf got %0d want 1", ovf_cnt); end
      for (int i = 0; i < 17; i++) begin
         step(0, 4'b0000, 0, 0, 1);
         n_cmp += 2;
         if (rd_valid !== m_rdv) begin n_err++; $display("FAIL fill_rd_valid[%0d] got %b want %b", i, rd_valid, m_rdv); end
         if (rd_data !== m_rdd) begin n_err++; $display("FAIL fill_rd_data[%0d] got %h want %h", i, rd_data, m_rdd); end
      end
      n_cmp++;
      if (m_rdv !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL fill_drained got empty=%b want 1", empty); end
   endtask

   task automatic test_full_rw();
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, 4'($urandom_range(0, 15)), 1, 1, 0);
      step(1, 4'($urandom_range(0, 15)), 1, 1, 1);
      n_cmp += 5;
      if (count !== 5'd16) begin n_err++; $display("FAIL fullrw_count got %0d want 16", count); end
      if (full !== 1'b1) begin n_err++; $display("FAIL fullrw_full got %b want 1", full); end
      if (ovf_cnt !== 16'd0) begin n_err++; $display("FAIL fullrw_ovf got %0d want 0", ovf_cnt); end
      if (rd_valid !== 1'b1) begin n_err++; $display("FAIL fullrw_rd_valid got %b want 1", rd_valid); end
      if (rd_data !== {16'd0, rd_data[3:0]} || rd_data !== m_rdd) begin
         n_err++; $display("FAIL fullrw_rd_data got %h want %h", rd_data, m_rdd);
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 4'b0000, 0, 0, 1);
         n_cmp++;
         if (rd_data !== m_rdd) begin n_err++; $display("FAIL fullrw_drain[%0d] got %h want %h", i, rd_data, m_rdd); end
      end
   endtask

   task automatic test_empty_read_wrap();
      step(0, 4'b0000, 0, 0, 1);
      n_cmp++;
      if (rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_rd_valid got %b want 0", rd_valid); end
      for (int i = 0; i < 20; i++) begin
         step(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, 0);
         step(0, 4'b0000, 0, 0, 1);
         n_cmp += 3;
         if (rd_valid !== 1'b1) begin n_err++; $display("FAIL wrap_rd_valid[%0d] got %b want 1", i, rd_valid); end
         if (rd_data !== m_rdd) begin n_err++; $display("FAIL wrap_rd_data[%0d] got %h want %h", i, rd_data, m_rdd); end
         if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty[%0d] got %b want 1", i, empty); end
      end
   endtask

   task automatic test_overwrite_policy();
      logic [15:0] want_seq;
`ifdef MATCH_LOG_OVERWRITE_EN
      want_seq = 16'd2;
`else
      want_seq = 16'd0;
`endif
      do_reset();
      for (int i = 0; i < 18; i++) step(1, 4'($urandom_range(0, 15)), 1, 1, 0);
      n_cmp += 2;
      if (count !== 5'd16) begin n_err++; $display("FAIL ow_count got %0d want 16", count); end
      if (ovf_cnt !== 16'd2) begin n_err++; $display("FAIL ow_ovf got %0d want 2", ovf_cnt); end
      step(0, 4'b0000, 0, 0, 1);
      n_cmp += 2;
      if (rd_data[19:4] !== want_seq) begin n_err++; $display("FAIL ow_first_seq got %0d want %0d", rd_data[19:4], want_seq); end
      if (rd_data !== m_rdd) begin n_err++; $display("FAIL ow_first_rec got %h want %h", rd_data, m_rdd); end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 5; i++) step(1, 4'($urandom_range(0, 15)), 1, 1, 0);
      rd_req = 1'b1;
      #2 rst = 1'b1;
      #1;
      n_cmp += 4;
      if (count !== 5'd0) begin n_err++; $display("FAIL midrst_count got %0d want 0", count); end
      if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty got %b want 1", empty); end
      if (rd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rd_valid got %b want 0", rd_valid); end
      if (rd_data !== 20'h0) begin n_err++; $display("FAIL midrst_rd_data got %h want 0", rd_data); end
      do_reset();
      step(0, 4'b0000, 0, 0, 1);
      n_cmp++;
      if (rd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_post_read got %b want 0", rd_valid); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 99) < 45));
         n_cmp += 6;
         if (count !== 5'(exp_q.size())) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, exp_q.size()); end
         if (full !== (exp_q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full[%0d] got %b", i, full); end
         if (empty !== (exp_q.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d] got %b", i, empty); end
         if (ovf_cnt !== 16'(m_ovf)) begin n_err++; $display("FAIL rnd_ovf[%0d] got %0d want %0d", i, ovf_cnt, m_ovf); end
         if (rd_valid !== m_rdv) begin n_err++; $display("FAIL rnd_rd_valid[%0d] got %b want %b", i, rd_valid, m_rdv); end
         if (rd_data !== m_rdd) begin n_err++; $display("FAIL rnd_rd_data[%0d] got %h want %h", i, rd_data, m_rdd); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_seq_capture();
      test_eop_same_cycle();
      test_fill_overflow();
      test_full_rw();
      test_empty_read_wrap();
      test_overwrite_policy();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
